sseg_scan_ctrl: RTL and testbench

MMIO-slot scan controller for an 8-digit, common-anode seven-segment display. It holds eight segment patterns written over the slot bus and sequences the anodes one digit at a time. Each digit gets a programmable dwell, a programmable lit (brightness) fraction and a blanking guard interval. Digits can be masked out. The block replaces free-running counter multiplexing in the MMIO subsystem and drives `an`/`sseg` pins directly.

---
 rtl/sseg_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller on an MMIO slot.
// Per-digit dwell, lit fraction, digit mask and a blanking guard between digits.
module sseg_scan_ctrl #(
  parameter int unsigned GUARD     = 4,
  parameter int unsigned DWELL_RST = 12500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_tick
);

  localparam int unsigned CW = 16;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {S_IDLE, S_LIT, S_DARK, S_GUARD} state_t;

  logic [7:0][7:0] pat_q;
  logic [CW-1:0]   dwell_q, lit_q;
  logic [7:0]      mask_q;
  logic            run_q;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   dwell_l_q, dwell_l_d, lit_l_q, lit_l_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            wrap_q, wrap_d;

  logic            slot_end_c;
  logic [CW-1:0]   dwell_eff_c;
  logic [IW-1:0]   first_idx_c, next_idx_c;

  logic            unused_in;
  assign unused_in = ^{read, addr[4:2]};

  // First enabled digit at or after start, searching cyclically.
  function automatic logic [IW-1:0] first_enabled(input logic [7:0] m, input logic [IW-1:0] start);
    logic [IW-1:0] j;
    first_enabled = start;
    for (int i = 7; i >= 0; i--) begin
      j = start + IW'(i);
      if (m[j]) first_enabled = j;
    end
  endfunction

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q   <= '1;
      dwell_q <= CW'(DWELL_RST);
      lit_q   <= '1;
      mask_q  <= '1;
      run_q   <= 1'b0;
    end else if (cs && write) begin
      case (addr[1:0])
        2'd0: pat_q[3:0] <= wr_data;
        2'd1: pat_q[7:4] <= wr_data;
        2'd2: begin
          lit_q   <= wr_data[31:16];
          dwell_q <= wr_data[15:0];
        end
        default: begin
          run_q  <= wr_data[16];
          mask_q <= wr_data[7:0];
        end
      endcase
    end
  end

  always_comb begin
    case (addr[1:0])
      2'd0:    rd_data = pat_q[3:0];
      2'd1:    rd_data = pat_q[7:4];
      2'd2:    rd_data = {lit_q, dwell_q};
      default: rd_data = {15'b0, run_q, 8'b0, mask_q};
    endcase
  end

  assign dwell_eff_c = (dwell_q == '0) ? CW'(1) : dwell_q;
  assign first_idx_c = first_enabled(mask_q, idx_q);
  assign next_idx_c  = first_enabled(mask_q, idx_q + IW'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dwell_l_q <= CW'(1);
      lit_l_q   <= '0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dwell_l_q <= dwell_l_d;
      lit_l_q   <= lit_l_d;
      idx_q     <= idx_d;
      wrap_q    <= wrap_d;
    end
  end

  // Next-state logic; slot end either leaves to IDLE or starts the next enabled digit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_l_d  = dwell_l_q;
    lit_l_d    = lit_l_q;
    idx_d      = idx_q;
    wrap_d     = 1'b0;
    slot_end_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_q && (mask_q != '0)) begin
          idx_d     = first_idx_c;
          cnt_d     = '0;
          dwell_l_d = dwell_eff_c;
          lit_l_d   = lit_q;
          state_d   = (lit_q != '0) ? S_LIT : S_DARK;
        end
      end
      S_LIT, S_DARK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == dwell_l_q - CW'(1)) begin
          if (GUARD == 0) begin
            slot_end_c = 1'b1;
          end else begin
            state_d = S_GUARD;
            cnt_d   = '0;
          end
        end else if ((state_q == S_LIT) && (cnt_q == lit_l_q - CW'(1))) begin
          state_d = S_DARK;
        end
      end
      S_GUARD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GUARD - 1)) slot_end_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (slot_end_c) begin
      cnt_d = '0;
      if (!run_q || (mask_q == '0)) begin
        state_d = S_IDLE;
      end else begin
        idx_d     = next_idx_c;
        dwell_l_d = dwell_eff_c;
        lit_l_d   = lit_q;
        wrap_d    = (next_idx_c <= idx_q);
        state_d   = (lit_q != '0) ? S_LIT : S_DARK;
      end
    end
  end

  // Pin register, one cycle behind the state register; patterns are read live
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an         <= 8'hFF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap_q;
      if (state_q == S_LIT) begin
        an   <= ~(8'd1 << idx_q);
        sseg <= pat_q[idx_q];
      end else begin
        an   <= 8'hFF;
        sseg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: slot-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized register traffic.
module tb_sseg_scan_ctrl;

  localparam int G = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  an, sseg;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  sseg_scan_ctrl #(.GUARD(G)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Register mirror and slot model: a slot is dwell+G cycles, lit for the first min(lit,dwell)
  logic [7:0]  mp [8];
  logic [15:0] m_dwell, m_lit;
  logic [7:0]  m_mask;
  logic        m_run;
  bit          m_busy, m_wrap, lit_now;
  int          m_idx, m_pos, m_dw, m_lt, n_idx;
  logic [7:0]  exp_an, exp_sseg;
  logic        exp_ft;

  function automatic int first_from(input logic [7:0] m, input int start);
    for (int i = 0; i < 8; i++) if (m[(start + i) % 8]) return (start + i) % 8;
    return start % 8;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {mp[3], mp[2], mp[1], mp[0]};
      2'd1:    return {mp[7], mp[6], mp[5], mp[4]};
      2'd2:    return {m_lit, m_dwell};
      default: return {15'b0, m_run, 8'b0, m_mask};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 8; i++) mp[i] = 8'hFF;
        m_dwell = 16'd12500; m_lit = 16'hFFFF; m_mask = 8'hFF; m_run = 1'b0;
        m_busy = 0; m_wrap = 0; m_idx = 0; m_pos = 0; m_dw = 1; m_lt = 0;
        exp_an = 8'hFF; exp_sseg = 8'hFF; exp_ft = 1'b0;
      end else begin
        lit_now  = m_busy && (m_pos < ((m_lt < m_dw) ? m_lt : m_dw));
        exp_an   = lit_now ? ~(8'd1 << m_idx) : 8'hFF;
        exp_sseg = lit_now ? mp[m_idx] : 8'hFF;
        exp_ft   = m_wrap;
        m_wrap   = 0;
        n_idx    = -1;
        if (!m_busy) begin
          if (m_run && m_mask != 0) n_idx = first_from(m_mask, m_idx);
        end else if (m_pos == m_dw + G - 1) begin
          if (!m_run || m_mask == 0) m_busy = 0;
          else begin
            n_idx  = first_from(m_mask, m_idx + 1);
            m_wrap = (n_idx <= m_idx);
          end
        end else begin
          m_pos++;
        end
        if (n_idx >= 0) begin
          m_idx = n_idx; m_pos = 0; m_busy = 1;
          m_dw = (m_dwell == 0) ? 1 : int'(m_dwell);
          m_lt = int'(m_lit);
        end
        if (cs && write) begin
          case (addr[1:0])
            2'd0: for (int i = 0; i < 4; i++) mp[i] = wr_data[8*i +: 8];
            2'd1: for (int i = 0; i < 4; i++) mp[4+i] = wr_data[8*i +: 8];
            2'd2: begin m_lit = wr_data[31:16]; m_dwell = wr_data[15:0]; end
            default: begin m_run = wr_data[16]; m_mask = wr_data[7:0]; end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an", {24'b0, an}, {24'b0, exp_an});
      check("sseg", {24'b0, sseg}, {24'b0, exp_sseg});
      check("frame_tick", {31'b0, frame_tick}, {31'b0, exp_ft});
      check("rd_data", rd_data, exp_rd(addr[1:0]));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    cs = 1'b1; write = 1'b1; addr = {3'b000, a}; wr_data = d;
    @(posedge clk); #2;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] want, input string name);
    @(posedge clk); #2;
    addr = {3'b000, a};
    #1 check(name, rd_data, want);
  endtask

  task automatic wait_an(input logic [7:0] v, input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (an !== v && n < budget) begin @(negedge clk); n++; end
    if (an !== v) check(name, {24'b0, an}, {24'b0, v});
  endtask

  task automatic wait_ft(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    if (frame_tick !== 1'b1) check(name, {31'b0, frame_tick}, 32'd1);
  endtask

  function automatic logic [31:0] ctl(input bit run, input logic [7:0] mask);
    return {15'b0, run, 8'b0, mask};
  endfunction

  logic [7:0] seq1 [12];
  int c_ft, c_lit;
  logic [31:0] rnd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    seq1 = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF,
             8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFF, 8'hFF};
    cs = 0; read = 0; write = 0; addr = '0; wr_data = '0; reset_n = 1'b1;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    check("rst_an", {24'b0, an}, 32'hFF);
    check("rst_ft", {31'b0, frame_tick}, 32'd0);
    rd_chk(2'd0, 32'hFFFF_FFFF, "rst_reg0");
    rd_chk(2'd2, {16'hFFFF, 16'd12500}, "rst_reg2");
    rd_chk(2'd3, 32'h0000_00FF, "rst_reg3");

    // Two digits, full brightness: FE x4, FF x2, FB x4, FF x2
    wr(2'd2, {16'd4, 16'd4});
    wr(2'd3, ctl(1, 8'h05));
    @(negedge clk); check("start_t0", {24'b0, an}, 32'hFF);
    @(negedge clk); check("start_t1", {24'b0, an}, 32'hFF);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("s1_an", {24'b0, an}, {24'b0, seq1[k % 12]});
      check("s1_ft", {31'b0, frame_tick}, (k == 12) ? 32'd1 : 32'd0);
    end

    // Single digit, lit 3 of 8, slot 10
    wr(2'd2, {16'd3, 16'd8});
    wr(2'd3, ctl(1, 8'h01));
    repeat (30) @(negedge clk);
    wait_ft(40, "s2_sync");
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check("s2_an", {24'b0, an}, (k % 10 < 3) ? 32'hFE : 32'hFF);
      check("s2_ft", {31'b0, frame_tick}, (k % 10 == 0) ? 32'd1 : 32'd0);
    end

    // lit = 0: dark but still framing (slot 7)
    wr(2'd2, {16'd0, 16'd5});
    repeat (20) @(negedge clk);
    c_ft = 0; c_lit = 0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      c_ft += int'(frame_tick);
      if (an !== 8'hFF) c_lit++;
    end
    check("lit0_dark", c_lit, 0);
    check("lit0_ft", c_ft, 4);

    // dwell = 0 acts as 1: slot 3
    wr(2'd2, {16'hFFFF, 16'd0});
    repeat (20) @(negedge clk);
    c_ft = 0; c_lit = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      c_ft += int'(frame_tick);
      if (an === 8'hFE) c_lit++;
    end
    check("dw0_lit", c_lit, 10);
    check("dw0_ft", c_ft, 10);

    // Stop mid-slot on digit 3, then resume there
    wr(2'd2, {16'd6, 16'd6});
    wr(2'd3, ctl(1, 8'h09));
    wait_an(8'hFF, 40, "s5_guard");
    wait_an(8'hF7, 100, "s5_d3");
    wr(2'd3, ctl(0, 8'h09));
    repeat (12) @(negedge clk);
    c_lit = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (an !== 8'hFF) c_lit++;
    end
    check("stop_dark", c_lit, 0);
    wr(2'd3, ctl(1, 8'h09));
    wait_an(8'hF7, 4, "resume_d3");

    // Live pattern write on the lit digit, then async reset mid-slot
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, {16'd12, 16'd12});
    wr(2'd3, ctl(1, 8'h01));
    wait_an(8'hFF, 40, "s6_gap");
    wait_an(8'hFE, 60, "s6_d0");
    wr(2'd0, 32'hFFFF_FFC0);
    @(negedge clk);
    @(negedge clk);
    check("pat_live", {24'b0, sseg}, 32'hC0);
    check("pat_an", {24'b0, an}, 32'hFE);
    check("pat_rd", rd_data, 32'hFFFF_FFC0);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("arst_an", {24'b0, an}, 32'hFF);
    check("arst_sseg", {24'b0, sseg}, 32'hFF);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rd_chk(2'd3, 32'h0000_00FF, "arst_reg3");
    rd_chk(2'd0, 32'hFFFF_FFFF, "arst_reg0");

    // Randomized register traffic against the model
    for (int it = 0; it < 90; it++) begin
      case ($urandom_range(0, 5))
        0: wr(2'($urandom_range(0, 1)), $urandom);
        1: wr(2'd2, {16'($urandom_range(0, 14)), 16'($urandom_range(0, 12))});
        2, 3: begin
          rnd = $urandom;
          rnd[16] = ($urandom_range(0, 3) != 0);
          rnd[7:0] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
          wr(2'd3, rnd);
        end
        4: begin
          @(posedge clk); #2;
          cs = 1'b1; read = 1'b1; addr = 5'($urandom);
          @(posedge clk); #2;
          cs = 1'b0; read = 1'b0;
        end
        default: @(posedge clk);
      endcase
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
